nibble_serial_adder_ctrl: RTL

Sequencer that computes a WIDTH-bit add with carry-in by time-multiplexing one 4-bit ripple adder over WIDTH/4 cycles, least-significant nibble first. The carry is chained through a register between nibbles. It uses a start/busy/done handshake. It sits between a requester (testbench or upstream control) and the shared 4-bit adder datapath, and trades latency for area on wide adds.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_adder_ctrl_if.sv | 17 +
 rtl/nibble_serial_adder_ctrl_nibble_add.sv | 23 ++
 rtl/nibble_serial_adder_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding, nibble width and index sizing.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The nibble index must still be at least one bit wide when there is only one nibble.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_add.sv
// 4-bit combinational ripple adder; c3 exposes the carry into the top bit for overflow detection.
module nibble_add
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBW-1:0] a,
    input  logic [NIBW-1:0] b,
    input  logic            ci,
    output logic [NIBW-1:0] s,
    output logic            co,
    output logic            c3
);
    logic [NIBW:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < NIBW; gi++) begin : g_bit
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co = c[NIBW];
    assign c3 = c[NIBW-1];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add with carry-in computed one nibble per cycle, LSB nibble first, through a single 4-bit adder.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NIB  = WIDTH / NIBW;
    localparam int IDXW = idx_width(NIB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [NIBW-1:0]   nib_a, nib_b, nib_s;
    logic              nib_co, nib_c3;
    logic              accept;

    assign nib_a = a_q[NIBW*idx_q +: NIBW];
    assign nib_b = b_q[NIBW*idx_q +: NIBW];

    nibble_add u_nibble_add (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    // A start is honoured in IDLE and also in DONE, which gives back-to-back throughput.
    assign accept = bus.start && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_RUN: begin
                sum_d[NIBW*idx_q +: NIBW] = nib_s;
                carry_d = nib_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = nib_co;
                    ovf_d   = nib_c3 ^ nib_co;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_IDLE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            idx_d   = '0;
            sum_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
